// File: rtl/bsr_pkg.sv
// Shared definitions for the boundary-scan register chain.
// Holds the 2-bit instruction-mode type and its encodings, as decoded by the TAP controller.
package bsr_pkg;

    typedef logic [1:0] bsr_mode_t;

    localparam bsr_mode_t BSR_NORMAL         = 2'd0;
    localparam bsr_mode_t BSR_SAMPLE_PRELOAD = 2'd1;
    localparam bsr_mode_t BSR_EXTEST         = 2'd2;
    localparam bsr_mode_t BSR_INTEST         = 2'd3;

endpackage

// File: rtl/bsr_cell.sv
// One boundary-scan cell: a shift flop and an update flop.
// Ports:
//   tck, trst_n   test clock (rising edge) and asynchronous active-low reset
//   capture_en    load shift flop from par_in
//   shift_en      load shift flop from ser_in
//   update_en     copy shift flop into update flop
//   par_in        parallel capture data
//   ser_in        serial data from the previous stage (or TDI)
//   sr, ur        shift flop and update flop contents
// Strobe priority is resolved by the caller; this cell still prefers capture over shift
// so that it stays well-defined if both enables are ever asserted together.
module bsr_cell (
    input  logic tck,
    input  logic trst_n,
    input  logic capture_en,
    input  logic shift_en,
    input  logic update_en,
    input  logic par_in,
    input  logic ser_in,
    output logic sr,
    output logic ur
);

    logic sr_q;
    logic ur_q;

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            sr_q <= 1'b0;
        end else if (capture_en) begin
            sr_q <= par_in;
        end else if (shift_en) begin
            sr_q <= ser_in;
        end
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ur_q <= 1'b0;
        end else if (update_en) begin
            ur_q <= sr_q;
        end
    end

    assign sr = sr_q;
    assign ur = ur_q;

endmodule

// File: rtl/bsr_chain.sv
// Parametrised boundary-scan register chain.
// Chain order TDI -> TDO: in[0]..in[N_IN-1], out[0]..out[N_OUT-1], oe.
// Ports:
//   tck, trst_n                     test clock, asynchronous active-low reset
//   tdi, tdo                        serial scan in / out (tdo = last shift stage)
//   select                          chain selected; gates all strobes
//   capture_dr, shift_dr, update_dr TAP strobes (priority capture > shift > update)
//   mode                            NORMAL / SAMPLE_PRELOAD / EXTEST / INTEST
//   pin_in  -> core_out             input cells (pin to core)
//   core_in -> pin_out              output cells (core to pin)
//   core_oe -> pin_oe               shared output-enable control cell
// Build option: define BSR_INTEST_EN to enable INTEST; otherwise mode 3 is transparent.
module bsr_chain
    import bsr_pkg::*;
#(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned N_OUT = 2
) (
    input  logic             tck,
    input  logic             trst_n,
    input  logic             tdi,
    output logic             tdo,
    input  logic             select,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic [1:0]       mode,
    input  logic [N_IN-1:0]  pin_in,
    output logic [N_IN-1:0]  core_out,
    input  logic [N_OUT-1:0] core_in,
    input  logic             core_oe,
    output logic [N_OUT-1:0] pin_out,
    output logic             pin_oe
);

    localparam int unsigned L = N_IN + N_OUT + 1;

    logic         capture_en;
    logic         shift_en;
    logic         update_en;
    logic [L-1:0] par_in;
    logic [L-1:0] ser_in;
    logic [L-1:0] sr;
    logic [L-1:0] ur;

    logic [N_IN-1:0]  ur_in;
    logic [N_OUT-1:0] ur_out;
    logic             ur_oe;

    // A lower-priority strobe on the same edge as a higher one is dropped.
    assign capture_en = select & capture_dr;
    assign shift_en   = select & shift_dr & ~capture_dr;
    assign update_en  = select & update_dr & ~capture_dr & ~shift_dr;

    assign par_in = {core_oe, core_in, pin_in};
    assign ser_in = {sr[L-2:0], tdi};

    for (genvar k = 0; k < L; k++) begin : g_cell
        bsr_cell u_cell (
            .tck        (tck),
            .trst_n     (trst_n),
            .capture_en (capture_en),
            .shift_en   (shift_en),
            .update_en  (update_en),
            .par_in     (par_in[k]),
            .ser_in     (ser_in[k]),
            .sr         (sr[k]),
            .ur         (ur[k])
        );
    end

    assign tdo    = sr[L-1];
    assign ur_in  = ur[N_IN-1:0];
    assign ur_out = ur[N_IN+N_OUT-1:N_IN];
    assign ur_oe  = ur[L-1];

`ifndef BSR_INTEST_EN
    // Input-cell update flops still take preloads but never reach the core.
    logic unused_ur_in;
    assign unused_ur_in = ^ur_in;
`endif

    always_comb begin
        core_out = pin_in;
        pin_out  = core_in;
        pin_oe   = core_oe;
        case (mode)
            BSR_EXTEST: begin
                pin_out = ur_out;
                pin_oe  = ur_oe;
            end
`ifdef BSR_INTEST_EN
            BSR_INTEST: begin
                core_out = ur_in;
                pin_out  = ur_out;
                pin_oe   = 1'b0;  // keep pins tristated while the core is under test
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bsr_chain.sv
// Self-checking bench for bsr_chain (N_IN=2, N_OUT=2, chain length 5).
// Expected values follow BSR_INTEST_EN when it is defined for the build.
module tb_bsr_chain;

    logic       tck = 1'b0;
    logic       trst_n;
    logic       tdi;
    logic       tdo;
    logic       select;
    logic       capture_dr;
    logic       shift_dr;
    logic       update_dr;
    logic [1:0] mode;
    logic [1:0] pin_in;
    logic [1:0] core_out;
    logic [1:0] core_in;
    logic       core_oe;
    logic [1:0] pin_out;
    logic       pin_oe;

    int n_checks = 0;
    int n_fail   = 0;

    bsr_chain #(
        .N_IN  (2),
        .N_OUT (2)
    ) dut (
        .tck        (tck),
        .trst_n     (trst_n),
        .tdi        (tdi),
        .tdo        (tdo),
        .select     (select),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .mode       (mode),
        .pin_in     (pin_in),
        .core_out   (core_out),
        .core_in    (core_in),
        .core_oe    (core_oe),
        .pin_out    (pin_out),
        .pin_oe     (pin_oe)
    );

    always #5 tck = ~tck;

    typedef struct {
        logic       cap;
        logic       shf;
        logic       upd;
        logic       sel;
        logic       din;
        logic [1:0] md;
        logic [1:0] pi;
        logic [1:0] ci;
        logic       oe;
        logic       e_tdo;
        logic [1:0] e_co;
        logic [1:0] e_po;
        logic       e_oe;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic c, logic s, logic u, logic sl, logic d, logic [1:0] m,
                                logic [1:0] p, logic [1:0] ci, logic o, logic et,
                                logic [1:0] eco, logic [1:0] epo, logic eoe);
        vec_t v;
        v.cap = c; v.shf = s; v.upd = u; v.sel = sl; v.din = d; v.md = m;
        v.pi = p; v.ci = ci; v.oe = o;
        v.e_tdo = et; v.e_co = eco; v.e_po = epo; v.e_oe = eoe;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic u, input logic sl,
                         input logic d, input logic [1:0] m, input logic [1:0] p,
                         input logic [1:0] ci, input logic o);
        capture_dr = c; shift_dr = s; update_dr = u; select = sl; tdi = d;
        mode = m; pin_in = p; core_in = ci; core_oe = o;
    endtask

    task automatic edge1();
        @(posedge tck);
        #1;
    endtask

    task automatic shift_bit(input logic d);
        drive(1'b0, 1'b1, 1'b0, 1'b1, d, mode, pin_in, core_in, core_oe);
        edge1();
    endtask

    task automatic update_now();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mode, pin_in, core_in, core_oe);
        edge1();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mode, pin_in, core_in, core_oe);
    endtask

    initial begin
        //            c  s  u  sel d  mode   pin    core   oe  | tdo core_o pin_o  pin_oe
        // Sample: capture then shift out oe, out1, out0, in1, in0
        vecs[0]  = mk(1, 0, 0, 1, 0, 2'd1, 2'b10, 2'b01, 1,  1, 2'b10, 2'b01, 1);
        vecs[1]  = mk(0, 1, 0, 1, 0, 2'd1, 2'b10, 2'b01, 1,  0, 2'b10, 2'b01, 1);
        vecs[2]  = mk(0, 1, 0, 1, 0, 2'd1, 2'b10, 2'b01, 1,  1, 2'b10, 2'b01, 1);
        vecs[3]  = mk(0, 1, 0, 1, 0, 2'd1, 2'b10, 2'b01, 1,  1, 2'b10, 2'b01, 1);
        vecs[4]  = mk(0, 1, 0, 1, 0, 2'd1, 2'b10, 2'b01, 1,  0, 2'b10, 2'b01, 1);
        // Preload 1,1,0,1,0 -> oe=1 out1=1 out0=0 in1=1 in0=0
        vecs[5]  = mk(0, 1, 0, 1, 1, 2'd1, 2'b10, 2'b01, 1,  0, 2'b10, 2'b01, 1);
        vecs[6]  = mk(0, 1, 0, 1, 1, 2'd1, 2'b10, 2'b01, 1,  0, 2'b10, 2'b01, 1);
        vecs[7]  = mk(0, 1, 0, 1, 0, 2'd1, 2'b10, 2'b01, 1,  0, 2'b10, 2'b01, 1);
        vecs[8]  = mk(0, 1, 0, 1, 1, 2'd1, 2'b10, 2'b01, 1,  0, 2'b10, 2'b01, 1);
        vecs[9]  = mk(0, 1, 0, 1, 0, 2'd1, 2'b10, 2'b01, 1,  1, 2'b10, 2'b01, 1);
        vecs[10] = mk(0, 0, 1, 1, 0, 2'd1, 2'b10, 2'b01, 1,  1, 2'b10, 2'b01, 1);
        // EXTEST: pins from update flops, core-side changes ignored
        vecs[11] = mk(0, 0, 0, 1, 0, 2'd2, 2'b10, 2'b01, 1,  1, 2'b10, 2'b10, 1);
        vecs[12] = mk(0, 0, 0, 1, 0, 2'd2, 2'b01, 2'b10, 0,  1, 2'b01, 2'b10, 1);
        vecs[13] = mk(0, 0, 0, 1, 0, 2'd2, 2'b01, 2'b11, 0,  1, 2'b01, 2'b10, 1);
        // All strobes together: capture wins, update dropped
        vecs[14] = mk(1, 1, 1, 1, 1, 2'd2, 2'b01, 2'b00, 0,  0, 2'b01, 2'b10, 1);
        vecs[15] = mk(0, 1, 0, 1, 0, 2'd2, 2'b01, 2'b00, 0,  0, 2'b01, 2'b10, 1);
        // Shift with update: update dropped
        vecs[16] = mk(0, 1, 1, 1, 1, 2'd2, 2'b01, 2'b00, 0,  0, 2'b01, 2'b10, 1);
        // select low: nothing moves
        vecs[17] = mk(1, 1, 1, 0, 1, 2'd2, 2'b11, 2'b11, 1,  0, 2'b11, 2'b10, 1);
        vecs[18] = mk(0, 0, 1, 0, 0, 2'd2, 2'b11, 2'b11, 1,  0, 2'b11, 2'b10, 1);
        // Update exposes shift state kept through the deselected cycles: out0=1 out1=0 oe=0
        vecs[19] = mk(0, 0, 1, 1, 0, 2'd2, 2'b11, 2'b11, 1,  0, 2'b11, 2'b01, 0);
        vecs[20] = mk(0, 0, 0, 1, 0, 2'd0, 2'b11, 2'b11, 1,  0, 2'b11, 2'b11, 1);

        // Reset state
        trst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'b10, 2'b11, 1'b1);
        #12;
        chk("reset_tdo", {7'd0, tdo}, 8'd0);
        chk("reset_pin_out", {6'd0, pin_out}, 8'd0);
        chk("reset_pin_oe", {7'd0, pin_oe}, 8'd0);
        @(negedge tck);
        trst_n = 1'b1;
        #1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].cap, vecs[i].shf, vecs[i].upd, vecs[i].sel, vecs[i].din,
                  vecs[i].md, vecs[i].pi, vecs[i].ci, vecs[i].oe);
            edge1();
            chk($sformatf("vec%0d_tdo", i), {7'd0, tdo}, {7'd0, vecs[i].e_tdo});
            chk($sformatf("vec%0d_core_out", i), {6'd0, core_out}, {6'd0, vecs[i].e_co});
            chk($sformatf("vec%0d_pin_out", i), {6'd0, pin_out}, {6'd0, vecs[i].e_po});
            chk($sformatf("vec%0d_pin_oe", i), {7'd0, pin_oe}, {7'd0, vecs[i].e_oe});
        end

        // Reset mid-shift after loading all ones into update flops
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'b00, 2'b00, 1'b1);
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        update_now();
        #1;
        chk("pre_reset_pin_out", {6'd0, pin_out}, 8'h03);
        chk("pre_reset_pin_oe", {7'd0, pin_oe}, 8'h01);
        shift_bit(1'b0);
        shift_bit(1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2, 2'b00, 2'b00, 1'b1);
        #2;
        trst_n = 1'b0;
        #1;
        chk("midreset_tdo", {7'd0, tdo}, 8'd0);
        chk("midreset_pin_out", {6'd0, pin_out}, 8'd0);
        chk("midreset_pin_oe", {7'd0, pin_oe}, 8'd0);
`ifdef BSR_INTEST_EN
        mode = 2'd3;
        #1;
        chk("midreset_core_out", {6'd0, core_out}, 8'd0);
        mode = 2'd2;
`endif
        @(negedge tck);
        trst_n = 1'b1;
        #1;

        // Walking one reaches tdo exactly on the fifth shift edge
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'b00, 2'b00, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            shift_bit(e == 1);
            chk($sformatf("walk_edge%0d", e), {7'd0, tdo}, {7'd0, e == 5});
        end

        // INTEST: preload in cells 11, out0=1 out1=0 oe=0
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'b00, 2'b10, 1'b1);
        shift_bit(1'b0);
        shift_bit(1'b0);
        shift_bit(1'b1);
        shift_bit(1'b1);
        shift_bit(1'b1);
        update_now();
        mode = 2'd3;
        #1;
`ifdef BSR_INTEST_EN
        chk("intest_core_out", {6'd0, core_out}, 8'h03);
        chk("intest_pin_out", {6'd0, pin_out}, 8'h01);
        chk("intest_pin_oe", {7'd0, pin_oe}, 8'h00);
`else
        chk("mode3_core_out", {6'd0, core_out}, 8'h00);
        chk("mode3_pin_out", {6'd0, pin_out}, 8'h02);
        chk("mode3_pin_oe", {7'd0, pin_oe}, 8'h01);
`endif
        pin_in = 2'b01;
        #1;
`ifdef BSR_INTEST_EN
        chk("intest_core_out_hold", {6'd0, core_out}, 8'h03);
`else
        chk("mode3_core_out_follow", {6'd0, core_out}, 8'h01);
`endif
        // Update flops survive a mode change back to EXTEST
        mode = 2'd2;
        #1;
        chk("extest_after_intest_pin_out", {6'd0, pin_out}, 8'h01);
        chk("extest_after_intest_pin_oe", {7'd0, pin_oe}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
